// File: rtl/brick_draw.sv
// brick_draw -- redraws a COLS x ROWS brick grid into a 160x120 frame buffer,
// one pixel per clock, after a single-cycle go pulse.
//
// Ports:
//   clk          system clock
//   resetn       synchronous, active-low reset
//   go           start a full-grid redraw (accepted only when idle)
//   brick_alive  one bit per brick, index row*COLS+col (snapshotted on go)
//   x, y         pixel address (8-bit column, 7-bit row)
//   colour       3-bit RGB pixel colour
//   plot         frame-buffer write enable
//   busy         high for every pixel cycle of a scan
//   done         one-cycle pulse after the last pixel cycle
//
// Build option: define BRICK_DRAW_ERASE_EN to paint dead bricks black
// (plot=1, colour=0); by default dead-brick pixels are skipped (plot=0).
module brick_draw #(
  parameter int COLS    = 8,
  parameter int ROWS    = 4,
  parameter int BRICK_W = 16,
  parameter int BRICK_H = 4,
  parameter int X0      = 16,
  parameter int Y0      = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 go,
  input  logic [COLS*ROWS-1:0] brick_alive,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 done
);

  localparam int NB  = COLS * ROWS;
  localparam int PXW = (BRICK_W > 1) ? $clog2(BRICK_W) : 1;
  localparam int PYW = (BRICK_H > 1) ? $clog2(BRICK_H) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [7:0] X0_8 = 8'(X0);
  localparam logic [7:0] BW_8 = 8'(BRICK_W);
  localparam logic [6:0] Y0_7 = 7'(Y0);
  localparam logic [6:0] BH_7 = 7'(BRICK_H);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // The grid must fit the 160x120 frame so 8/7-bit address arithmetic never wraps.
  if ((X0 + COLS * BRICK_W > 160) || (Y0 + ROWS * BRICK_H > 120)) begin : g_bad_params
    $error("brick_draw: brick grid does not fit the 160x120 frame");
  end

  logic [1:0]     state;
  logic [PXW-1:0] px,  px_n;
  logic [PYW-1:0] py,  py_n;
  logic [CW-1:0]  col, col_n;
  logic [RW-1:0]  row, row_n;
  logic [NB-1:0]  snapshot;
  logic           last_px, last_py, last_col, last_row, last_pixel;

  // Alive bit of brick (frow, fcol) taken from a brick vector.
  function automatic logic alive_at(input logic [NB-1:0] vec, input logic [RW-1:0] frow,
                                    input logic [CW-1:0] fcol);
    logic [NB-1:0] sh;
    sh = vec >> (int'(frow) * COLS + int'(fcol));
    return sh[0];
  endfunction

  // {plot, colour} for one pixel; the last column/row of each cell is the gap.
  function automatic logic [3:0] pixel_of(input logic [PXW-1:0] fpx, input logic [PYW-1:0] fpy,
                                          input logic [RW-1:0] frow, input logic alive);
    logic       gap;
    logic [7:0] row8;
    logic [3:0] r;
    gap  = (fpx == PXW'(BRICK_W - 1)) || (fpy == PYW'(BRICK_H - 1));
    row8 = 8'(frow);
    if (alive) begin
      if (gap) begin
        r = 4'b1000;
      end else begin
        r = {1'b1, 3'(row8 % 8'd7) + 3'd1};
      end
    end else begin
`ifdef BRICK_DRAW_ERASE_EN
      r = 4'b1000;
`else
      r = 4'b0000;
`endif
    end
    return r;
  endfunction

  // Wrap flags and next scan position; px is fastest, row slowest.
  always_comb begin
    last_px    = (px  == PXW'(BRICK_W - 1));
    last_py    = (py  == PYW'(BRICK_H - 1));
    last_col   = (col == CW'(COLS - 1));
    last_row   = (row == RW'(ROWS - 1));
    last_pixel = last_px && last_py && last_col && last_row;
    px_n  = px + PXW'(1);
    py_n  = py;
    col_n = col;
    row_n = row;
    if (last_px) begin
      px_n = '0;
      py_n = py + PYW'(1);
      if (last_py) begin
        py_n  = '0;
        col_n = col + CW'(1);
        if (last_col) begin
          col_n = '0;
          row_n = row + RW'(1);
        end
      end
    end
  end

  // Sequencer: counters always describe the pixel currently on the outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      px       <= '0;
      py       <= '0;
      col      <= '0;
      row      <= '0;
      snapshot <= '0;
      x        <= 8'd0;
      y        <= 7'd0;
      colour   <= 3'd0;
      plot     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // Quiet outputs unless a pixel is being emitted below.
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (go) begin
            state    <= SCAN;
            snapshot <= brick_alive;
            px       <= '0;
            py       <= '0;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            x        <= X0_8;
            y        <= Y0_7;
            // Snapshot is not loaded yet, so pixel 0 reads the live input.
            {plot, colour} <= pixel_of('0, '0, '0, alive_at(brick_alive, '0, '0));
          end else begin
            state <= IDLE;
          end
        end
        SCAN: begin
          if (last_pixel) begin
            state <= DONE;
            px    <= '0;
            py    <= '0;
            col   <= '0;
            row   <= '0;
            done  <= 1'b1;
          end else begin
            state <= SCAN;
            px    <= px_n;
            py    <= py_n;
            col   <= col_n;
            row   <= row_n;
            busy  <= 1'b1;
            x     <= X0_8 + 8'(col_n) * BW_8 + 8'(px_n);
            y     <= Y0_7 + 7'(row_n) * BH_7 + 7'(py_n);
            {plot, colour} <= pixel_of(px_n, py_n, row_n, alive_at(snapshot, row_n, col_n));
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_draw.sv
// Self-checking bench for brick_draw (default parameters): every output cycle
// of each scan is compared against a pixel model computed from the scan index.
module tb_brick_draw;

  localparam int COLS = 8, ROWS = 4, BW = 16, BH = 4, X0 = 16, Y0 = 8;
  localparam int NPIX = COLS * ROWS * BW * BH;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        go = 1'b0;
  logic [31:0] brick_alive = 32'd0;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  brick_draw dut (
    .clk(clk), .resetn(resetn), .go(go), .brick_alive(brick_alive),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] obs();
    return {x, y, colour, plot, busy, done};
  endfunction

  // Expected {x,y,colour,plot,busy,done} at scan cycle k: k<0 or k>NPIX idle,
  // k==NPIX the done cycle.
  function automatic logic [20:0] model(input logic [31:0] vec, input int k);
    int px, py, cl, rw, ex, ey, c;
    logic [31:0] sh;
    logic alive, gap, pl;
    if (k < 0 || k > NPIX) return 21'd0;
    if (k == NPIX) return 21'd1;
    px = k % BW;
    py = (k / BW) % BH;
    cl = (k / (BW * BH)) % COLS;
    rw = k / (BW * BH * COLS);
    sh = vec >> (rw * COLS + cl);
    alive = sh[0];
    gap = (px == BW - 1) || (py == BH - 1);
    ex = X0 + cl * BW + px;
    ey = Y0 + rw * BH + py;
    c = 0;
    if (alive) begin
      pl = 1'b1;
      c = gap ? 0 : (rw % 7) + 1;
    end else begin
`ifdef BRICK_DRAW_ERASE_EN
      pl = 1'b1;
`else
      pl = 1'b0;
`endif
    end
    return {8'(ex), 7'(ey), 3'(c), pl, 1'b1, 1'b0};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    go = 1'b1;
    brick_alive = $urandom;
    step();
    step();
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL reset: got %h expected %h", obs(), 21'd0);
    end
  endtask

  // Also checks that go in the first cycle out of reset is accepted.
  task automatic test_all_alive();
    logic [31:0] vec;
    vec = 32'hFFFF_FFFF;
    brick_alive = vec;
    resetn = 1'b1;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k <= NPIX + 1; k++) begin
      n_tests++;
      if (obs() !== model(vec, k)) begin
        n_fail++;
        $display("FAIL all_alive k=%0d: got %h expected %h", k, obs(), model(vec, k));
      end
      if (k == 0) begin
        n_tests++;
        if ({x, y, colour, plot} !== {8'd16, 7'd8, 3'd1, 1'b1}) begin
          n_fail++;
          $display("FAIL first_pixel: got x=%0d y=%0d c=%0d p=%b expected 16 8 1 1", x, y, colour, plot);
        end
      end
      if (k == NPIX - 1) begin
        n_tests++;
        if ({x, y, colour, plot} !== {8'd143, 7'd23, 3'd0, 1'b1}) begin
          n_fail++;
          $display("FAIL last_pixel: got x=%0d y=%0d c=%0d p=%b expected 143 23 0 1", x, y, colour, plot);
        end
      end
      step();
    end
  endtask

  task automatic test_single_brick();
    logic [31:0] vec;
    int plotted, want;
`ifdef BRICK_DRAW_ERASE_EN
    vec = ~(32'd1 << 9);
    want = NPIX;
`else
    vec = 32'd1 << 9;
    want = 64;
`endif
    plotted = 0;
    brick_alive = vec;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k <= NPIX + 1; k++) begin
      n_tests++;
      if (obs() !== model(vec, k)) begin
        n_fail++;
        $display("FAIL single_brick k=%0d: got %h expected %h", k, obs(), model(vec, k));
      end
      if (plot) plotted++;
      step();
    end
    n_tests++;
    if (plotted != want) begin
      n_fail++;
      $display("FAIL single_brick_count: got %0d plotted expected %0d", plotted, want);
    end
  endtask

  task automatic test_random();
    logic [31:0] vec;
    for (int t = 0; t < 3; t++) begin
      vec = $urandom;
      brick_alive = vec;
      go = 1'b1;
      step();
      go = 1'b0;
      brick_alive = $urandom;
      for (int k = 0; k <= NPIX + 1; k++) begin
        n_tests++;
        if (obs() !== model(vec, k)) begin
          n_fail++;
          $display("FAIL random t=%0d k=%0d: got %h expected %h", t, k, obs(), model(vec, k));
        end
        step();
      end
    end
  endtask

  task automatic test_disturb();
    logic [31:0] vec;
    vec = $urandom;
    brick_alive = vec;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k <= NPIX + 1; k++) begin
      n_tests++;
      if (obs() !== model(vec, k)) begin
        n_fail++;
        $display("FAIL disturb k=%0d: got %h expected %h", k, obs(), model(vec, k));
      end
      if (k == 100) begin
        brick_alive = ~vec;
        go = 1'b1;
      end
      step();
      go = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] vec;
    vec = $urandom;
    brick_alive = vec;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k < 500; k++) begin
      n_tests++;
      if (obs() !== model(vec, k)) begin
        n_fail++;
        $display("FAIL reset_mid_pre k=%0d: got %h expected %h", k, obs(), model(vec, k));
      end
      step();
    end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (obs() !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_mid_quiet i=%0d: got %h expected %h", i, obs(), 21'd0);
      end
      step();
    end
    vec = $urandom;
    brick_alive = vec;
    go = 1'b1;
    step();
    go = 1'b0;
    for (int k = 0; k <= NPIX + 1; k++) begin
      n_tests++;
      if (obs() !== model(vec, k)) begin
        n_fail++;
        $display("FAIL reset_mid_rescan k=%0d: got %h expected %h", k, obs(), model(vec, k));
      end
      step();
    end
  endtask

  // go held high: scan, done, one idle cycle, next scan -> period NPIX+2.
  task automatic test_back_to_back();
    logic [31:0] vec;
    vec = $urandom;
    brick_alive = vec;
    go = 1'b1;
    step();
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k <= NPIX + 1; k++) begin
        if (s == 1 && k == NPIX + 1) go = 1'b0;
        n_tests++;
        if (obs() !== model(vec, k)) begin
          n_fail++;
          $display("FAIL back_to_back s=%0d k=%0d: got %h expected %h", s, k, obs(), model(vec, k));
        end
        step();
      end
    end
    n_tests++;
    if (obs() !== 21'd0) begin
      n_fail++;
      $display("FAIL back_to_back_idle: got %h expected %h", obs(), 21'd0);
    end
  endtask

  initial begin
    test_reset();
    test_all_alive();
    test_single_brick();
    test_random();
    test_disturb();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/brick_draw.md
BRICK_DRAW -- requirements
Module: brick_draw

Interface
REQ-001 SHALL have parameter COLS, default 8, bricks per row.
REQ-002 SHALL have parameter ROWS, default 4, brick rows.
REQ-003 SHALL have parameter BRICK_W, default 16, cell width in pixels including the 1-pixel gap.
REQ-004 SHALL have parameter BRICK_H, default 4, cell height in pixels including the 1-pixel gap.
REQ-005 SHALL have parameter X0, default 16, left pixel of the grid.
REQ-006 SHALL have parameter Y0, default 8, top pixel of the grid.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port resetn, input, 1, reset; synchronous, active-low.
REQ-009 SHALL have port go, input, 1, start a full-grid redraw; single-cycle pulse from the draw sequencer.
REQ-010 SHALL have port brick_alive, input, COLS*ROWS, one bit per brick; bit index is row*COLS+col.
REQ-011 SHALL have port x, output, 8, pixel column for the 160x120 frame buffer.
REQ-012 SHALL have port y, output, 7, pixel row.
REQ-013 SHALL have port colour, output, 3, RGB pixel colour.
REQ-014 SHALL have port plot, output, 1, write-enable to the frame buffer.
REQ-015 SHALL have port busy, output, 1, high from the cycle after go is accepted through the last pixel cycle.
REQ-016 SHALL have port done, output, 1, single-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, SCAN and DONE with transitions IDLE->SCAN on go, SCAN->DONE after the last pixel, and DONE->IDLE unconditionally.
REQ-018 SHALL accept go only in IDLE and ignore it in SCAN and DONE, including go asserted in the same cycle as done.
REQ-019 SHALL latch brick_alive into a snapshot register on the accepting edge, so that input changes during SCAN have no effect.
REQ-020 SHALL scan with counters px (fastest), then py, then col, then row, all starting at 0 and each wrapping to 0 when the next-outer counter advances.
REQ-021 SHALL spend exactly one cycle per pixel, giving a SCAN length of exactly COLS*ROWS*BRICK_W*BRICK_H cycles (2048 at defaults), independent of brick_alive.
REQ-022 SHALL register all outputs, with x = X0+col*BRICK_W+px and y = Y0+row*BRICK_H+py.
REQ-023 SHALL present the first pixel (0,0,0,0) on outputs in the cycle after the edge that samples go.
REQ-024 SHALL, for a pixel of an alive brick with px<BRICK_W-1 and py<BRICK_H-1, drive plot=1 and colour=(row mod 7)+1, which is never black.
REQ-025 SHALL, for gap pixels (px=BRICK_W-1 or py=BRICK_H-1) of an alive brick, drive plot=1 and colour=0.
REQ-026 SHALL handle dead-brick pixels per REQ-033 and REQ-034.
REQ-027 SHALL assert done for exactly the one cycle after the last pixel cycle, with busy=0 and plot=0 in that cycle.
REQ-028 SHALL hold plot=0 whenever busy=0.
REQ-029 SHALL size all address arithmetic at 8 bits (x) and 7 bits (y); parameter sets with X0+COLS*BRICK_W>160 or Y0+ROWS*BRICK_H>120 are illegal and SHALL be rejected at elaboration.

Reset
REQ-030 SHALL, on resetn=0 at a clock edge, set state=IDLE, all counters=0, snapshot=0, and x=0, y=0, colour=0, plot=0, busy=0, done=0.
REQ-031 SHALL, on reset mid-SCAN, abandon the scan immediately without emitting done, with outputs as in REQ-030 after that edge.
REQ-032 SHALL accept a go asserted in the first cycle with resetn=1.

Configuration
REQ-033 SHALL, with macro BRICK_DRAW_ERASE_EN defined, drive all pixels of dead bricks with plot=1 and colour=0, erasing them.
REQ-034 SHALL, without BRICK_DRAW_ERASE_EN, drive dead-brick pixels with plot=0; x and y still advance and cycle count is unchanged.

Verification
REQ-035 SHALL cover: all bits set, go pulse -> 2048 consecutive plot=1 cycles, the first at (16,8) with colour 1 and the last at (143,23) with colour 0, then done=1 for one cycle.
REQ-036 SHALL cover: only bit 9 set (row 1, col 1), macro undefined -> plot=1 only for x 32..47 and y 12..15, with colour 2 at x 32..46 and y 12..14 and colour 0 on gap pixels.
REQ-037 SHALL cover: bit 9 clear, macro defined -> the 64 pixels at x 32..47, y 12..15 plotted with colour 0.
REQ-038 SHALL cover: brick_alive toggled and go re-pulsed at cycle 100 of SCAN -> output identical to an undisturbed run, with no restart.
REQ-039 SHALL cover: resetn low at cycle 500 of SCAN -> all outputs 0 the next cycle, no done; a subsequent go produces a full 2048-cycle scan.
REQ-040 SHALL cover: go held high continuously -> a new scan starts one cycle after each done (IDLE visited for one cycle), with period 2050 cycles.
